// File: rtl/vdp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vdp_seq_pkg
// Purpose  : Shared op codes, FSM state encoding, host-port flag constants
//            and setup-byte helpers for the TMS9918 host sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package vdp_seq_pkg;

  // Command op codes carried on cmd_op
  localparam logic [1:0] OP_REG_WR  = 2'd0;
  localparam logic [1:0] OP_VRAM_WR = 2'd1;
  localparam logic [1:0] OP_VRAM_RD = 2'd2;
  localparam logic [1:0] OP_FILL    = 2'd3;

  // Top-level FSM encoding
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_VBL  = 3'd1;
  localparam state_t ST_ADDR_LO   = 3'd2;
  localparam state_t ST_ADDR_HI   = 3'd3;
  localparam state_t ST_DATA_WR   = 3'd4;
  localparam state_t ST_DATA_FILL = 3'd5;
  localparam state_t ST_DATA_RD   = 3'd6;

  // Second setup byte flags: register write / VRAM write address
  localparam logic [7:0] VDP_REG_FLAG = 8'h80;
  localparam logic [7:0] VDP_WR_FLAG  = 8'h40;

  // First setup byte: register value for REG_WR, else low address byte
  function automatic logic [7:0] addr_lo_byte(input logic [1:0]  op,
                                              input logic [13:0] addr,
                                              input logic [7:0]  data);
    return (op == OP_REG_WR) ? data : addr[7:0];
  endfunction

  // Second setup byte: register select, or high address with write flag
  function automatic logic [7:0] addr_hi_byte(input logic [1:0]  op,
                                              input logic [13:0] addr);
    logic [7:0] v;
    case (op)
      OP_REG_WR:  v = VDP_REG_FLAG | {5'b00000, addr[2:0]};
      OP_VRAM_RD: v = {2'b00, addr[13:8]};
      default:    v = VDP_WR_FLAG | {2'b00, addr[13:8]};
    endcase
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vdp_bus_cycle.sv
`default_nettype none
// ============================================================================
// Module   : vdp_bus_cycle
// Purpose  : One host-port byte access: SETUP (1 cycle), STROBE (WR_PULSE or
//            RD_PULSE cycles), RECOVER (RECOVER cycles). A new start may be
//            issued while idle or in the cycle that done is high, giving
//            gap-free back-to-back accesses.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_bus_cycle #(
  parameter int WR_PULSE = 1,
  parameter int RD_PULSE = 4,
  parameter int RECOVER  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       is_read,
  input  logic [7:0] data_byte,
  output logic       idle,
  output logic       done,
  output logic       sample,
  output logic       strobe_wr,
  output logic       strobe_rd,
  output logic [7:0] dout
);

  localparam int c_MAX_A = (WR_PULSE > RD_PULSE) ? WR_PULSE : RD_PULSE;
  localparam int c_MAX   = (c_MAX_A > RECOVER) ? c_MAX_A : RECOVER;
  localparam int c_CW    = (c_MAX > 1) ? $clog2(c_MAX) : 1;

  localparam logic [c_CW-1:0] c_WR_LOAD  = c_CW'(WR_PULSE - 1);
  localparam logic [c_CW-1:0] c_RD_LOAD  = c_CW'(RD_PULSE - 1);
  localparam logic [c_CW-1:0] c_REC_LOAD = (RECOVER > 0) ? c_CW'(RECOVER - 1) : '0;

  localparam logic [1:0] c_PH_IDLE    = 2'd0;
  localparam logic [1:0] c_PH_SETUP   = 2'd1;
  localparam logic [1:0] c_PH_STROBE  = 2'd2;
  localparam logic [1:0] c_PH_RECOVER = 2'd3;

  logic [1:0]      r_phase;
  logic [c_CW-1:0] r_cnt;
  logic            r_is_read;
  logic [7:0]      r_dout;
  logic            w_last_strobe;
  logic            w_last_recover;

  assign w_last_strobe  = (r_phase == c_PH_STROBE)  && (r_cnt == '0);
  assign w_last_recover = (r_phase == c_PH_RECOVER) && (r_cnt == '0);

  assign idle      = (r_phase == c_PH_IDLE);
  assign done      = (RECOVER == 0) ? w_last_strobe : w_last_recover;
  assign sample    = w_last_strobe && r_is_read;
  assign strobe_wr = (r_phase == c_PH_STROBE) && !r_is_read;
  assign strobe_rd = (r_phase == c_PH_STROBE) &&  r_is_read;
  assign dout      = r_dout;

  // Phase sequencer; dout only reloads on a new start so it is held
  // from SETUP through the end of RECOVER.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_phase   <= c_PH_IDLE;
      r_cnt     <= '0;
      r_is_read <= 1'b0;
      r_dout    <= 8'h00;
    end else begin
      case (r_phase)
        c_PH_SETUP: begin
          r_phase <= c_PH_STROBE;
          r_cnt   <= r_is_read ? c_RD_LOAD : c_WR_LOAD;
        end
        c_PH_STROBE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (RECOVER != 0) begin
            r_phase <= c_PH_RECOVER;
            r_cnt   <= c_REC_LOAD;
          end else begin
            r_phase <= c_PH_IDLE;
          end
        end
        c_PH_RECOVER: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_phase <= c_PH_IDLE;
          end
        end
        default: r_phase <= c_PH_IDLE;
      endcase
      if (start && (idle || done)) begin
        r_phase   <= c_PH_SETUP;
        r_dout    <= data_byte;
        r_is_read <= is_read;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vdp_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : vdp_host_sequencer
// Purpose  : Drives the TMS9918 host port for register writes, VRAM block
//            writes, VRAM fills and VRAM block reads, generating the two-byte
//            setup protocol and all strobe timing.
// Options  : VDP_SEQ_VSYNC_EN - adds vdp_int/cmd_sync; commands accepted with
//            cmd_sync=1 wait for the next rising edge of vdp_int.
// Revision : 1.0 - initial release
// ============================================================================
module vdp_host_sequencer #(
  parameter int WR_PULSE = 1,
  parameter int RD_PULSE = 4,
  parameter int RECOVER  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [13:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  input  logic [13:0] cmd_count,
  input  logic [7:0]  wdata,
  input  logic        wdata_valid,
  output logic        wdata_ready,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  output logic        busy,
  output logic        vdp_mode,
  output logic        vdp_wr,
  output logic        vdp_rd,
  output logic [7:0]  vdp_dout,
`ifdef VDP_SEQ_VSYNC_EN
  input  logic        vdp_int,
  input  logic        cmd_sync,
`endif
  input  logic [7:0]  vdp_din
);
  import vdp_seq_pkg::*;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [13:0] r_addr;
  logic [7:0]  r_data;
  logic [13:0] r_count;
  logic [7:0]  r_rdata;
  logic        r_rdata_valid;

  logic        w_start;
  logic        w_is_read;
  logic [7:0]  w_byte;
  logic        w_wdata_ready;
  logic        w_sync_req;
  logic        w_bus_idle;
  logic        w_done;
  logic        w_sample;
  logic        w_more;

`ifdef VDP_SEQ_VSYNC_EN
  logic r_int_q;
  logic w_int_rise;

  // One-cycle delayed copy of vdp_int for rising-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      r_int_q <= 1'b0;
    end else begin
      r_int_q <= vdp_int;
    end
  end

  assign w_int_rise = vdp_int && !r_int_q;
  assign w_sync_req = cmd_sync;
`else
  assign w_sync_req = 1'b0;
`endif

  // Another data byte may launch when the bus is free (stalled write) or
  // the current access ends with more bytes still owed.
  assign w_more = w_bus_idle || (w_done && (r_count != 14'd1));

  assign cmd_ready   = (r_state == ST_IDLE) && !reset;
  assign busy        = (r_state != ST_IDLE);
  assign vdp_mode    = (r_state == ST_ADDR_LO) || (r_state == ST_ADDR_HI);
  assign wdata_ready = w_wdata_ready;
  assign rdata       = r_rdata;
  assign rdata_valid = r_rdata_valid;

  // Decide when the next bus access starts and which byte it carries
  always_comb begin
    w_start       = 1'b0;
    w_is_read     = 1'b0;
    w_byte        = 8'h00;
    w_wdata_ready = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && !w_sync_req) begin
          w_start = 1'b1;
          w_byte  = addr_lo_byte(cmd_op, cmd_addr, cmd_data);
        end
      end
`ifdef VDP_SEQ_VSYNC_EN
      ST_WAIT_VBL: begin
        if (w_int_rise) begin
          w_start = 1'b1;
          w_byte  = addr_lo_byte(r_op, r_addr, r_data);
        end
      end
`endif
      ST_ADDR_LO: begin
        if (w_done) begin
          w_start = 1'b1;
          w_byte  = addr_hi_byte(r_op, r_addr);
        end
      end
      ST_ADDR_HI: begin
        if (w_done && (r_op != OP_REG_WR) && (r_count != 14'd0)) begin
          case (r_op)
            OP_VRAM_WR: begin
              if (wdata_valid) begin
                w_start       = 1'b1;
                w_byte        = wdata;
                w_wdata_ready = 1'b1;
              end
            end
            OP_FILL: begin
              w_start = 1'b1;
              w_byte  = r_data;
            end
            default: begin
              w_start   = 1'b1;
              w_is_read = 1'b1;
            end
          endcase
        end
      end
      ST_DATA_WR: begin
        if (w_more && wdata_valid) begin
          w_start       = 1'b1;
          w_byte        = wdata;
          w_wdata_ready = 1'b1;
        end
      end
      ST_DATA_FILL: begin
        if (w_more) begin
          w_start = 1'b1;
          w_byte  = r_data;
        end
      end
      ST_DATA_RD: begin
        if (w_more) begin
          w_start   = 1'b1;
          w_is_read = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Command latch, top FSM, remaining-byte count and read capture
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_op          <= 2'd0;
      r_addr        <= 14'd0;
      r_data        <= 8'h00;
      r_count       <= 14'd0;
      r_rdata       <= 8'h00;
      r_rdata_valid <= 1'b0;
    end else begin
      r_rdata_valid <= w_sample;
      if (w_sample) begin
        r_rdata <= vdp_din;
      end
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_op    <= cmd_op;
            r_addr  <= cmd_addr;
            r_data  <= cmd_data;
            r_count <= cmd_count;
            r_state <= w_sync_req ? ST_WAIT_VBL : ST_ADDR_LO;
          end
        end
`ifdef VDP_SEQ_VSYNC_EN
        ST_WAIT_VBL: begin
          if (w_int_rise) begin
            r_state <= ST_ADDR_LO;
          end
        end
`endif
        ST_ADDR_LO: begin
          if (w_done) begin
            r_state <= ST_ADDR_HI;
          end
        end
        ST_ADDR_HI: begin
          if (w_done) begin
            if ((r_op == OP_REG_WR) || (r_count == 14'd0)) begin
              r_state <= ST_IDLE;
            end else begin
              case (r_op)
                OP_VRAM_WR: r_state <= ST_DATA_WR;
                OP_FILL:    r_state <= ST_DATA_FILL;
                default:    r_state <= ST_DATA_RD;
              endcase
            end
          end
        end
        ST_DATA_WR, ST_DATA_FILL, ST_DATA_RD: begin
          if (w_done) begin
            r_count <= r_count - 14'd1;
            if (r_count == 14'd1) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  vdp_bus_cycle #(
    .WR_PULSE (WR_PULSE),
    .RD_PULSE (RD_PULSE),
    .RECOVER  (RECOVER)
  ) u_bus (
    .clk       (clk),
    .reset     (reset),
    .start     (w_start),
    .is_read   (w_is_read),
    .data_byte (w_byte),
    .idle      (w_bus_idle),
    .done      (w_done),
    .sample    (w_sample),
    .strobe_wr (vdp_wr),
    .strobe_rd (vdp_rd),
    .dout      (vdp_dout)
  );

endmodule
`default_nettype wire

// File: tb/tb_vdp_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_host_sequencer
// Purpose  : Scoreboard bench for vdp_host_sequencer with a behavioural
//            TMS9918 host-port model (VRAM, registers, read-ahead buffer).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_host_sequencer;
  import vdp_seq_pkg::*;

  localparam int WRP = 1;
  localparam int RDP = 4;
  localparam int REC = 2;

  typedef struct packed {
    logic       rd;
    logic       mode;
    logic [7:0] b;
  } bus_ev_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [13:0] cmd_addr = 14'd0;
  logic [7:0]  cmd_data = 8'h00;
  logic [13:0] cmd_count = 14'd0;
  logic [7:0]  wdata;
  logic        wdata_valid;
  logic        wdata_ready;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        busy;
  logic        vdp_mode;
  logic        vdp_wr;
  logic        vdp_rd;
  logic [7:0]  vdp_dout;
  logic [7:0]  vdp_din;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int n_wready = 0;
  int n_rvalid = 0;

  bus_ev_t    exp_bus[$];
  logic [7:0] exp_rd[$];
  logic [7:0] wq[$];

  // VDP model state
  logic [7:0]  vram [0:16383];
  logic [7:0]  vregs [0:7];
  logic [13:0] m_addr = 14'd0;
  logic        m_flag = 1'b0;
  logic [7:0]  m_latch = 8'h00;
  logic [7:0]  m_rbuf = 8'h00;
  logic        m_pwr = 1'b0;
  logic        m_prd = 1'b0;

  assign vdp_din = m_rbuf;

  vdp_host_sequencer #(
    .WR_PULSE (WRP),
    .RD_PULSE (RDP),
    .RECOVER  (REC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .cmd_count   (cmd_count),
    .wdata       (wdata),
    .wdata_valid (wdata_valid),
    .wdata_ready (wdata_ready),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .busy        (busy),
    .vdp_mode    (vdp_mode),
    .vdp_wr      (vdp_wr),
    .vdp_rd      (vdp_rd),
    .vdp_dout    (vdp_dout),
    .vdp_din     (vdp_din)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic exp_wr(input logic mode, input logic [7:0] b);
    bus_ev_t ev;
    ev.rd = 1'b0; ev.mode = mode; ev.b = b;
    exp_bus.push_back(ev);
  endtask

  task automatic exp_read(input logic [7:0] val);
    bus_ev_t ev;
    ev.rd = 1'b1; ev.mode = 1'b0; ev.b = 8'h00;
    exp_bus.push_back(ev);
    exp_rd.push_back(val);
  endtask

  // Called at a negedge; returns at the negedge after acceptance
  task automatic send_cmd(input logic [1:0] op, input logic [13:0] addr,
                          input logic [7:0] data, input logic [13:0] count);
    int n = 0;
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_count = count;
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) timeout_fail("cmd_accept");
    accept_cyc = cyc;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op = 2'd0; cmd_addr = 14'h3FFF; cmd_data = 8'hCC; cmd_count = 14'd9;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    if (busy) timeout_fail("wait_idle");
    @(negedge clk);
  endtask

  // Behavioural TMS9918 host port
  initial begin
    forever begin
      @(negedge clk);
      if (vdp_wr && !m_pwr) begin
        if (vdp_mode) begin
          if (!m_flag) begin
            m_latch = vdp_dout;
            m_flag  = 1'b1;
          end else begin
            m_flag = 1'b0;
            if (vdp_dout[7]) begin
              vregs[vdp_dout[2:0]] = m_latch;
            end else begin
              m_addr = {vdp_dout[5:0], m_latch};
              if (!vdp_dout[6]) begin
                m_rbuf = vram[m_addr];
                m_addr = m_addr + 14'd1;
              end
            end
          end
        end else begin
          vram[m_addr] = vdp_dout;
          m_addr = m_addr + 14'd1;
          m_flag = 1'b0;
        end
      end
      if (!vdp_rd && m_prd) begin
        m_rbuf = vram[m_addr];
        m_addr = m_addr + 14'd1;
      end
      m_pwr = vdp_wr;
      m_prd = vdp_rd;
    end
  end

  // Write-stream source: pops a byte after each valid&ready handshake
  initial begin
    logic took;
    took = 1'b0;
    wdata = 8'h00;
    wdata_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (took && wq.size() > 0) void'(wq.pop_front());
      if (wq.size() > 0) begin
        wdata_valid = 1'b1;
        wdata = wq[0];
      end else begin
        wdata_valid = 1'b0;
      end
      #1;
      took = wdata_valid && wdata_ready;
      if (wdata_ready) n_wready++;
    end
  end

  // Monitor: every strobe start and every rdata_valid pulse is scored
  initial begin
    logic pwr, prd, smode, mode_moved;
    int wrun, rrun;
    bus_ev_t ev;
    pwr = 1'b0; prd = 1'b0; smode = 1'b0; mode_moved = 1'b0;
    wrun = 0; rrun = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pwr = 1'b0; prd = 1'b0; wrun = 0; rrun = 0; mode_moved = 1'b0;
      end else begin
        if ((vdp_wr && !pwr) || (vdp_rd && !prd)) begin
          smode = vdp_mode;
          mode_moved = 1'b0;
          n_tests++;
          if (exp_bus.size() == 0) begin
            n_fail++;
            $display("FAIL bus_event: unexpected strobe rd=%0b mode=%0b byte=%02h",
                     vdp_rd, vdp_mode, vdp_dout);
          end else begin
            ev = exp_bus.pop_front();
            if (ev.rd !== vdp_rd || ev.mode !== vdp_mode || (!ev.rd && ev.b !== vdp_dout)) begin
              n_fail++;
              $display("FAIL bus_event: got rd=%0b mode=%0b byte=%02h expected rd=%0b mode=%0b byte=%02h",
                       vdp_rd, vdp_mode, vdp_dout, ev.rd, ev.mode, ev.b);
            end
          end
        end else if ((vdp_wr || vdp_rd) && vdp_mode !== smode) begin
          mode_moved = 1'b1;
        end
        if (vdp_wr) wrun++;
        if (vdp_rd) rrun++;
        if (!vdp_wr && pwr) begin
          check("wr_pulse_width", wrun, WRP);
          check("mode_stable_wr", mode_moved, 1'b0);
          wrun = 0;
        end
        if (!vdp_rd && prd) begin
          check("rd_pulse_width", rrun, RDP);
          check("mode_stable_rd", mode_moved, 1'b0);
          rrun = 0;
        end
        if (rdata_valid) begin
          n_rvalid++;
          n_tests++;
          if (exp_rd.size() == 0) begin
            n_fail++;
            $display("FAIL rdata: unexpected pulse with %02h", rdata);
          end else begin
            logic [7:0] e;
            e = exp_rd.pop_front();
            if (rdata !== e) begin
              n_fail++;
              $display("FAIL rdata: got %02h expected %02h", rdata, e);
            end
          end
        end
        pwr = vdp_wr;
        prd = vdp_rd;
      end
    end
  end

  // Watchdog
  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic gap_bad;
    for (int i = 0; i < 16384; i++) vram[i] = 8'hA5;
    for (int i = 0; i < 8; i++) vregs[i] = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1'b0);
    check("reset_outputs", {busy, vdp_wr, vdp_rd, vdp_mode, vdp_dout, rdata, rdata_valid, wdata_ready}, 0);
    reset = 1'b0;
    #1;
    check("cmd_ready_after_reset", cmd_ready, 1'b1);
    @(negedge clk);

    // REG_WR reg 1 = EA, plus accept-to-strobe latency
    exp_wr(1'b1, 8'hEA);
    exp_wr(1'b1, 8'h81);
    send_cmd(OP_REG_WR, 14'h0001, 8'hEA, 14'd0);
    n = 0;
    while (!vdp_wr && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("first_strobe_latency", cyc - accept_cyc, 2);
    wait_idle();
    check("reg1_value", vregs[1], 8'hEA);
    check("ready_after_reg_wr", cmd_ready, 1'b1);

    // VRAM_WR 0x0800, 4 bytes
    n_wready = 0;
    wq.push_back(8'hFF); wq.push_back(8'h56); wq.push_back(8'h55); wq.push_back(8'h55);
    exp_wr(1'b1, 8'h00); exp_wr(1'b1, 8'h48);
    exp_wr(1'b0, 8'hFF); exp_wr(1'b0, 8'h56); exp_wr(1'b0, 8'h55); exp_wr(1'b0, 8'h55);
    send_cmd(OP_VRAM_WR, 14'h0800, 8'h00, 14'd4);
    wait_idle();
    check("wdata_ready_pulses_4", n_wready, 4);
    check("vram_0800", {vram[14'h0800], vram[14'h0801], vram[14'h0802], vram[14'h0803]}, 32'hFF565555);
    check("vram_0804_untouched", vram[14'h0804], 8'hA5);

    // VRAM_WR with a stream underflow gap mid-transfer
    n_wready = 0;
    wq.push_back(8'h11); wq.push_back(8'h22);
    exp_wr(1'b1, 8'h00); exp_wr(1'b1, 8'h41);
    exp_wr(1'b0, 8'h11); exp_wr(1'b0, 8'h22); exp_wr(1'b0, 8'h33); exp_wr(1'b0, 8'h44);
    send_cmd(OP_VRAM_WR, 14'h0100, 8'h00, 14'd4);
    n = 0;
    while (wq.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    gap_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (vdp_wr || vdp_rd || vdp_mode || !busy) gap_bad = 1'b1;
    end
    check("underflow_gap_quiet", gap_bad, 1'b0);
    wq.push_back(8'h33); wq.push_back(8'h44);
    wait_idle();
    check("wdata_ready_pulses_gap", n_wready, 4);
    check("vram_0100", {vram[14'h0100], vram[14'h0101], vram[14'h0102], vram[14'h0103]}, 32'h11223344);

    // Address-only VRAM_WR (count 0)
    n_wready = 0;
    exp_wr(1'b1, 8'h67); exp_wr(1'b1, 8'h45);
    send_cmd(OP_VRAM_WR, 14'h0567, 8'h00, 14'd0);
    wait_idle();
    check("count0_no_wdata", n_wready, 0);

    // FILL 0x1000 x32 with 00, then read back two bytes
    exp_wr(1'b1, 8'h00); exp_wr(1'b1, 8'h50);
    for (int i = 0; i < 32; i++) exp_wr(1'b0, 8'h00);
    send_cmd(OP_FILL, 14'h1000, 8'h00, 14'd32);
    wait_idle();
    check("fill_last", vram[14'h101F], 8'h00);
    check("fill_past_end", vram[14'h1020], 8'hA5);
    n_rvalid = 0;
    exp_wr(1'b1, 8'h00); exp_wr(1'b1, 8'h10);
    exp_read(8'h00); exp_read(8'h00);
    send_cmd(OP_VRAM_RD, 14'h1000, 8'h00, 14'd2);
    wait_idle();
    check("rdata_valid_pulses_fill", n_rvalid, 2);

    // VRAM_WR 0x1234 then read it back
    wq.push_back(8'h5A); wq.push_back(8'hEE);
    exp_wr(1'b1, 8'h34); exp_wr(1'b1, 8'h52);
    exp_wr(1'b0, 8'h5A); exp_wr(1'b0, 8'hEE);
    send_cmd(OP_VRAM_WR, 14'h1234, 8'h00, 14'd2);
    wait_idle();
    n_rvalid = 0;
    exp_wr(1'b1, 8'h34); exp_wr(1'b1, 8'h12);
    exp_read(8'h5A); exp_read(8'hEE);
    send_cmd(OP_VRAM_RD, 14'h1234, 8'h00, 14'd2);
    wait_idle();
    check("rdata_valid_pulses_1234", n_rvalid, 2);
    check("exp_bus_drained", exp_bus.size(), 0);
    check("exp_rd_drained", exp_rd.size(), 0);

    // Reset during the first data strobe of a 16-byte FILL
    exp_wr(1'b1, 8'h00); exp_wr(1'b1, 8'h60);
    for (int i = 0; i < 16; i++) exp_wr(1'b0, 8'h77);
    send_cmd(OP_FILL, 14'h2000, 8'h77, 14'd16);
    n = 0;
    while (!(vdp_wr && !vdp_mode) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(vdp_wr && !vdp_mode)) timeout_fail("fill_strobe");
    reset = 1'b1;
    @(negedge clk);
    check("reset_drops_wr", vdp_wr, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_cmd_ready_low", cmd_ready, 1'b0);
    exp_bus.delete();
    reset = 1'b0;
    #1;
    check("ready_after_midop_reset", cmd_ready, 1'b1);
    @(negedge clk);
    check("fill_abandoned", {vram[14'h2000], vram[14'h2001]}, 16'h77A5);

    // Normal operation resumes after reset
    exp_wr(1'b1, 8'hF1); exp_wr(1'b1, 8'h87);
    send_cmd(OP_REG_WR, 14'h0007, 8'hF1, 14'd0);
    wait_idle();
    check("reg7_value", vregs[7], 8'hF1);
    check("final_exp_bus_drained", exp_bus.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
